// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Helpers work on a wide fixed width; callers size-cast the result back down.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    // Caller sign-extends x, so the MSB is the operand's sign bit.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? neg(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift a quotient bit into the partial
// remainder, subtract the divisor when it fits, and record the quotient bit.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH+1:0] w_sh;
    logic             w_ge;

    assign w_sh    = {rem_in, q_in[WIDTH-1]};
    assign w_ge    = (w_sh >= {2'b00, d});
    assign rem_out = (WIDTH+1)'(w_ge ? (w_sh - {2'b00, d}) : w_sh);
    assign q_out   = {q_in[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider with start/done handshake, optional signed mode,
// divide-by-zero detection and the -2^(W-1)/-1 overflow case.
//
// Handshake: start is accepted on a rising edge only while busy=0; busy stays high
// from that edge until the edge that raises done, and done is a one-cycle pulse
// qualifying quo/rem/div_by_zero, which then hold until the next result.
module seq_divider_param
    import div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               r_neg_q, r_neg_r, r_dbz;
    logic               r_busy, r_done, r_dbz_out;
    logic [WIDTH-1:0]   r_quo, r_rem_out;

    logic               w_sgn;
    logic [MAX_W-1:0]   w_a_ext, w_b_ext;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_q_neg, w_r_neg, w_q_nx;
    logic [WIDTH:0]     w_rem_nx;

    assign w_sgn   = SIGNED_EN && signed_mode;
    assign w_a_ext = w_sgn ? MAX_W'($signed(a)) : MAX_W'(a);
    assign w_b_ext = w_sgn ? MAX_W'($signed(b)) : MAX_W'(b);
    // |-2^(W-1)| still fits because the magnitude is treated as unsigned.
    assign w_a_abs = WIDTH'(abs_val(w_a_ext));
    assign w_b_abs = WIDTH'(abs_val(w_b_ext));
    assign w_q_neg = WIDTH'(neg(MAX_W'(r_q)));
    assign w_r_neg = WIDTH'(neg(MAX_W'(r_rem)));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .q_in    (r_q),
        .d       (r_d),
        .rem_out (w_rem_nx),
        .q_out   (w_q_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = (b == '0) ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nx = FIX;
            FIX:     w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            r_quo     <= '0;
            r_rem_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_neg_q <= w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= w_sgn && a[WIDTH-1];
                        if (b == '0) begin
                            r_q   <= '1;
                            r_rem <= {1'b0, a};
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= w_a_abs;
                            r_d   <= w_b_abs;
                            r_rem <= '0;
                            r_cnt <= CNT_INIT;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_q   <= w_q_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                FIX: begin
                    if (r_neg_q) r_q   <= w_q_neg;
                    if (r_neg_r) r_rem <= {1'b0, w_r_neg};
                end
                DONE: begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_quo     <= r_q;
                    r_rem_out <= r_rem[WIDTH-1:0];
                    r_dbz_out <= r_dbz;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quo         = r_quo;
    assign rem         = r_rem_out;
    assign div_by_zero = r_dbz_out;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench for seq_divider_param: directed vector table, hand-written
// corner sequences and randomized ops scored against an arithmetic model.
module tb_seq_divider_param;

    logic        clk = 1'b0;
    logic        rst, start, sm;
    logic [7:0]  a, b;
    logic        busy, done, dbz;
    logic [7:0]  quo, rem;
    logic [1:0]  dbg;

    logic        start2, sm2;
    logic [15:0] a2, b2;
    logic        busy2, done2, dbz2;
    logic [15:0] quo2, rem2;
    logic [1:0]  dbg2;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    seq_divider_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
        .busy(busy), .done(done), .quo(quo), .rem(rem), .div_by_zero(dbz),
        .dbg_state(dbg)
    );

    seq_divider_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut_u16 (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .quo(quo2), .rem(rem2), .div_by_zero(dbz2),
        .dbg_state(dbg2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truncating integer division; remainder follows the dividend's sign.
    function automatic logic [16:0] model(input logic [7:0] ai, input logic [7:0] bi, input logic smi);
        int sa, sb;
        logic [7:0] q, r;
        if (bi == 8'd0) return {1'b1, 8'hFF, ai};
        if (smi) begin
            sa = $signed(ai);
            sb = $signed(bi);
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
        end else begin
            q = ai / bi;
            r = ai % bi;
        end
        return {1'b0, q, r};
    endfunction

    // Issues one op; optionally pulses a bogus start with other operands at cycle glitch_at.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic smi,
                          input int glitch_at, output int lat, output int busy_cnt,
                          output logic got_done);
        @(negedge clk);
        a = ai; b = bi; sm = smi; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        got_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat   = i;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (i == glitch_at) begin
                a = ~ai; b = 8'd3; sm = ~smi; start = 1'b1;
            end
        end
    endtask

    initial begin
        int lat, bcnt, n_done;
        logic got;
        logic [16:0] e;
        logic [7:0] ra, rb;
        logic rs;

        rst = 1'b0; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quo",  32'(quo),  32'd0);
        check("reset_rem",  32'(rem),  32'd0);
        check("reset_dbz",  32'(dbz),  32'd0);
        check("reset_state", 32'(dbg), 32'd0);
        check("reset_quo16", 32'(quo2), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        tbl[0] = '{8'd7,   8'd2,   1'b0, 8'd3,   8'd1,   1'b0, 10};
        tbl[1] = '{8'd255, 8'd9,   1'b0, 8'd28,  8'd3,   1'b0, 10};
        tbl[2] = '{8'd63,  8'd8,   1'b0, 8'd7,   8'd7,   1'b0, 10};
        tbl[3] = '{8'd32,  8'd8,   1'b0, 8'd4,   8'd0,   1'b0, 10};
        tbl[4] = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 10};
        tbl[5] = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 10};
        tbl[6] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 10};
        tbl[7] = '{8'h2A,  8'h00,  1'b0, 8'hFF,  8'h2A,  1'b1, 1};
        tbl[8] = '{8'd7,   8'd2,   1'b0, 8'd3,   8'd1,   1'b0, 10};

        for (int k = 0; k < 9; k++) begin
            run_op(tbl[k].a, tbl[k].b, tbl[k].sm, 0, lat, bcnt, got);
            check($sformatf("tbl%0d_done", k), 32'(got), 32'd1);
            check($sformatf("tbl%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
            check($sformatf("tbl%0d_busycyc", k), 32'(bcnt), 32'(tbl[k].lat));
            check($sformatf("tbl%0d_busy_at_done", k), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_quo", k), 32'(quo), 32'(tbl[k].q));
            check($sformatf("tbl%0d_rem", k), 32'(rem), 32'(tbl[k].r));
            check($sformatf("tbl%0d_dbz", k), 32'(dbz), 32'(tbl[k].z));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_done_pulse", k), 32'(done), 32'd0);
        end

        // start with different operands while busy must be ignored
        run_op(8'd100, 8'd7, 1'b0, 3, lat, bcnt, got);
        check("busy_start_done", 32'(got), 32'd1);
        check("busy_start_lat", 32'(lat), 32'd10);
        check("busy_start_quo", 32'(quo), 32'd14);
        check("busy_start_rem", 32'(rem), 32'd2);

        // reset in the middle of an op discards it
        @(negedge clk);
        a = 8'd200; b = 8'd3; sm = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quo",  32'(quo),  32'd0);
        check("midrst_rem",  32'(rem),  32'd0);
        check("midrst_dbz",  32'(dbz),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_op(8'd15, 8'd3, 1'b0, 0, lat, bcnt, got);
        check("after_rst_lat", 32'(lat), 32'd10);
        check("after_rst_quo", 32'(quo), 32'd5);
        check("after_rst_rem", 32'(rem), 32'd0);

        // randomized ops, each issued in the cycle right after the previous done
        for (int k = 0; k < 60; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'h80; rb = 8'hFF; rs = 1'b1;
            end
            exp_q.push_back(model(ra, rb, rs));
            run_op(ra, rb, rs, 0, lat, bcnt, got);
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_lat a=%h b=%h s=%b", k, ra, rb, rs), 32'(lat),
                  (rb == 8'd0) ? 32'd1 : 32'd10);
            check($sformatf("rnd%0d_result a=%h b=%h s=%b", k, ra, rb, rs),
                  32'({dbz, quo, rem}), 32'(e));
        end

        // unsigned-only build ignores signed_mode
        @(negedge clk);
        a2 = 16'hFFFF; b2 = 16'h0002; sm2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (done2) begin
                got = 1'b1;
                break;
            end
        end
        check("u16_done", 32'(got), 32'd1);
        check("u16_lat", 32'(lat), 32'd18);
        check("u16_quo", 32'(quo2), 32'h7FFF);
        check("u16_rem", 32'(rem2), 32'h0001);
        check("u16_dbz", 32'(dbz2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
